// File: rtl/wb_master_lsu.sv
// wb_master_lsu
// Wishbone initiator for single load/store requests from the core.
// Builds byte-lane selects and lane-replicated store data, sign- or
// zero-extends load data, rejects misaligned/illegal accesses without
// touching the bus, and aborts a bus cycle that is never acknowledged.
//
// Ports:
//   i_clk, i_rst_n              clock, async active-low reset
//   i_req, i_we, i_size,        request: start, store/load, size
//   i_unsigned, i_addr, i_wdata   (00 byte, 01 half, 10 word), ext mode,
//                                 byte address, right-aligned store data
//   o_busy, o_done, o_err       status: not idle, completion pulse, error
//   o_rdata                     extended load data (held between loads)
//   o_wb_cyc/stb/we/addr/       Wishbone master outputs
//     data/sel
//   i_wb_ack, i_wb_stall,       Wishbone slave responses
//     i_wb_data
module wb_master_lsu #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [31:0]           o_rdata,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  output logic [31:0]           o_wb_data,
  output logic [3:0]            o_wb_sel,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stall,
  input  logic [31:0]           i_wb_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Byte-lane enables for an access of the given size at byte offset lo.
  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   lane_sel = 4'b0001 << lo;
      2'b01:   lane_sel = 4'b0011 << lo;
      2'b10:   lane_sel = 4'b1111;
      default: lane_sel = 4'b0000;
    endcase
  endfunction

  // Store data replicated across all lanes so the slave picks it up
  // from whichever lanes are selected.
  function automatic logic [31:0] store_data(input logic we, input logic [1:0] size,
                                             input logic [31:0] wdata);
    if (!we) begin
      store_data = 32'h0000_0000;
    end else begin
      case (size)
        2'b00:   store_data = {4{wdata[7:0]}};
        2'b01:   store_data = {2{wdata[15:0]}};
        default: store_data = wdata;
      endcase
    end
  endfunction

  // Accesses that must be rejected before any bus cycle is started.
  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   bad_access = 1'b0;
      2'b01:   bad_access = lo[0];
      2'b10:   bad_access = |lo;
      default: bad_access = 1'b1;
    endcase
  endfunction

  // Pick the addressed lane(s) out of the bus word and extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                              input logic [1:0] lo, input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {lo, 3'b000};
    case (size)
      2'b00:   load_extend = {{24{~uns & sh[7]}},  sh[7:0]};
      2'b01:   load_extend = {{16{~uns & sh[15]}}, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  state_t                  state_r, state_nxt_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
  logic [1:0]              size_r, size_nxt_s;
  logic                    uns_r, uns_nxt_s;
  logic [1:0]              lo_r, lo_nxt_s;
  logic                    busy_nxt_s, done_nxt_s, err_nxt_s;
  logic [31:0]             rdata_nxt_s;
  logic                    cyc_nxt_s, stb_nxt_s, we_nxt_s;
  logic [ADDR_WIDTH-1:0]   addr_nxt_s;
  logic [31:0]             wbdata_nxt_s;
  logic [3:0]              sel_nxt_s;
  logic                    ack_s;

  // An ack only counts in REQ once stb is accepted, or anywhere in WAIT.
  always_comb begin
    ack_s = 1'b0;
    if ((state_r == REQ && !i_wb_stall) || state_r == WAIT) begin
      ack_s = i_wb_ack;
    end else begin
      ack_s = 1'b0;
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    size_nxt_s   = size_r;
    uns_nxt_s    = uns_r;
    lo_nxt_s     = lo_r;
    done_nxt_s   = 1'b0;
    err_nxt_s    = 1'b0;
    rdata_nxt_s  = o_rdata;
    cyc_nxt_s    = o_wb_cyc;
    stb_nxt_s    = o_wb_stb;
    we_nxt_s     = o_wb_we;
    addr_nxt_s   = o_wb_addr;
    wbdata_nxt_s = o_wb_data;
    sel_nxt_s    = o_wb_sel;
    case (state_r)
      IDLE: begin
        if (i_req) begin
          size_nxt_s   = i_size;
          uns_nxt_s    = i_unsigned;
          lo_nxt_s     = i_addr[1:0];
          we_nxt_s     = i_we;
          addr_nxt_s   = {i_addr[ADDR_WIDTH-1:2], 2'b00};
          wbdata_nxt_s = store_data(i_we, i_size, i_wdata);
          sel_nxt_s    = lane_sel(i_size, i_addr[1:0]);
          if (bad_access(i_size, i_addr[1:0])) begin
            state_nxt_s = DONE;
            done_nxt_s  = 1'b1;
            err_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = REQ;
            cyc_nxt_s   = 1'b1;
            stb_nxt_s   = 1'b1;
            cnt_nxt_s   = '0;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ, WAIT: begin
        if (ack_s) begin
          state_nxt_s = DONE;
          done_nxt_s  = 1'b1;
          cyc_nxt_s   = 1'b0;
          stb_nxt_s   = 1'b0;
          if (!o_wb_we) begin
            rdata_nxt_s = load_extend(size_r, uns_r, lo_r, i_wb_data);
          end else begin
            rdata_nxt_s = o_rdata;
          end
        end else if (cnt_r == CNT_LAST) begin
          // Limit reached with no ack: abandon the cycle, keep o_rdata.
          state_nxt_s = DONE;
          done_nxt_s  = 1'b1;
          err_nxt_s   = 1'b1;
          cyc_nxt_s   = 1'b0;
          stb_nxt_s   = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
          if (state_r == REQ && !i_wb_stall) begin
            stb_nxt_s   = 1'b0;
            state_nxt_s = WAIT;
          end else begin
            state_nxt_s = state_r;
          end
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        cyc_nxt_s   = 1'b0;
        stb_nxt_s   = 1'b0;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State, request context and all outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      size_r    <= 2'b00;
      uns_r     <= 1'b0;
      lo_r      <= 2'b00;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_rdata   <= 32'h0000_0000;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= 32'h0000_0000;
      o_wb_sel  <= 4'b0000;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      size_r    <= size_nxt_s;
      uns_r     <= uns_nxt_s;
      lo_r      <= lo_nxt_s;
      o_busy    <= busy_nxt_s;
      o_done    <= done_nxt_s;
      o_err     <= err_nxt_s;
      o_rdata   <= rdata_nxt_s;
      o_wb_cyc  <= cyc_nxt_s;
      o_wb_stb  <= stb_nxt_s;
      o_wb_we   <= we_nxt_s;
      o_wb_addr <= addr_nxt_s;
      o_wb_data <= wbdata_nxt_s;
      o_wb_sel  <= sel_nxt_s;
    end
  end

endmodule

// File: tb/tb_wb_master_lsu.sv
module tb_wb_master_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_addr, wb_dout, wb_din;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_master_lsu #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_size(size),
    .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_err(err), .o_rdata(rdata),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_addr(wb_addr), .o_wb_data(wb_dout), .o_wb_sel(wb_sel),
    .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_data(wb_din)
  );

  // ---------------- memory slave (registered ack) ----------------
  logic [31:0] mem [16];
  logic        ack_r = 1'b0;
  logic [31:0] rd_r = 32'h0;
  bit          comb_ack = 1'b0;
  bit          no_ack = 1'b0;
  int          acc_cnt = 0;
  bit          pl_en = 1'b0;
  int          pl_idx = 0;
  logic [31:0] pl_val = 32'h0;
  logic        bus_accept;

  assign bus_accept = wb_cyc && wb_stb && !wb_stall;
  assign wb_ack = no_ack ? 1'b0 : (comb_ack ? bus_accept : ack_r);
  assign wb_din = comb_ack ? mem[wb_addr[5:2]] : rd_r;

  always @(posedge clk) begin
    ack_r <= 1'b0;
    if (pl_en) mem[pl_idx] <= pl_val;
    if (bus_accept) begin
      ack_r   <= 1'b1;
      rd_r    <= mem[wb_addr[5:2]];
      acc_cnt <= acc_cnt + 1;
      if (wb_we)
        for (int b = 0; b < 4; b++)
          if (wb_sel[b]) mem[wb_addr[5:2]][8*b +: 8] <= wb_dout[8*b +: 8];
    end
  end

  // ---------------- reference model ----------------
  function automatic bit m_bad(input logic [1:0] sz, input logic [31:0] a);
    int n;
    n = 1 << sz;
    return (sz == 2'd3) || ((a % n) != 0);
  endfunction

  function automatic logic [3:0] m_sel(input logic [1:0] sz, input logic [31:0] a);
    int n, v;
    n = 1 << sz;
    v = ((1 << n) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wbd(input logic w, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    int n;
    n = 1 << sz;
    r = 32'h0;
    if (w)
      for (int b = 0; b < 4; b++) r[8*b +: 8] = d[8*(b % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic u,
                                         input logic [31:0] a, input logic [31:0] word);
    longint v, span;
    int n;
    n = 1 << sz;
    span = longint'(1) << (8 * n);
    v = (longint'(word) >> (8 * (a % 4))) % span;
    if (!u && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] old, input logic [3:0] s,
                                          input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request and observe it to completion (bounded).
  task automatic do_access(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] d, input int nstall,
                           output logic [31:0] r_rdata, output logic r_err,
                           output logic [3:0] r_sel, output logic [31:0] r_wbd,
                           output logic [31:0] r_wba, output logic r_we, output logic r_busy,
                           output int lat, output int cyc_cycles, output int stb_cycles,
                           output bit stable);
    int used;
    bit got;
    @(negedge clk);
    we = w; size = sz; uns = u; addr = a; wdata = d; req = 1'b1; wb_stall = 1'b0;
    @(posedge clk);
    #1 req = 1'b0;
    lat = -1; cyc_cycles = 0; stb_cycles = 0; stable = 1'b1; used = 0; got = 1'b0;
    r_rdata = 32'h0; r_err = 1'b0; r_sel = 4'h0; r_wbd = 32'h0; r_wba = 32'h0;
    r_we = 1'b0; r_busy = 1'b0;
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge clk);
      if (wb_cyc) cyc_cycles++;
      if (wb_cyc && wb_stb) begin
        if (stb_cycles == 0) begin
          r_sel = wb_sel; r_wbd = wb_dout; r_wba = wb_addr; r_we = wb_we;
        end else if (wb_sel !== r_sel || wb_dout !== r_wbd || wb_addr !== r_wba ||
                     wb_we !== r_we) begin
          stable = 1'b0;
        end
        stb_cycles++;
        wb_stall = (used < nstall);
        if (wb_stall) used++;
      end else begin
        wb_stall = 1'b0;
      end
      if (done) begin
        got = 1'b1; lat = c; r_rdata = rdata; r_err = err; r_busy = busy;
      end
    end
    wb_stall = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          init;
    logic [31:0] init_word;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wbd;
    logic [31:0] exp_mem;
    int          exp_lat;
  } vec_t;

  vec_t        tbl [12];
  logic [31:0] g_rdata, g_wbd, g_wba, last_rdata, exp_word, old_word;
  logic        g_err, g_we, g_busy;
  logic [3:0]  g_sel;
  int          g_lat, g_cyc, g_stb, acc0, idx;
  bit          g_stable, bad, done_seen;
  int          nst;

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = 32'h0; wdata = 32'h0; wb_stall = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_idx = i; pl_val = 32'h0;
    end
    @(negedge clk);
    pl_en = 1'b0;
    check("reset_outputs", {busy, done, err, rdata, wb_cyc, wb_stb, wb_we, wb_addr,
                            wb_dout, wb_sel} == '0 ? 32'd1 : 32'd0, 32'd1);
    rst_n = 1'b1;

    //          we  sz    u   addr  wdata       init word          rdata        err  sel   wbd          mem          lat
    tbl[0]  = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0,       1, 32'hFF718393, 32'hFF718393, 1'b0, 4'hF, 32'h0,        32'h0,        3};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h3, 32'h0,       1, 32'h80A1B2C3, 32'hFFFFFF80, 1'b0, 4'h8, 32'h0,        32'h0,        3};
    tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h3, 32'h0,       0, 32'h0,        32'h00000080, 1'b0, 4'h8, 32'h0,        32'h0,        3};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h1, 32'h0,       0, 32'h0,        32'hFFFFFFB2, 1'b0, 4'h2, 32'h0,        32'h0,        3};
    tbl[4]  = '{1'b1, 2'd1, 1'b0, 32'h6, 32'h1234ABCD,1, 32'h11112222, 32'hFFFFFFB2, 1'b0, 4'hC, 32'hABCDABCD, 32'hABCD2222, 3};
    tbl[5]  = '{1'b0, 2'd1, 1'b1, 32'h6, 32'h0,       0, 32'h0,        32'h0000ABCD, 1'b0, 4'hC, 32'h0,        32'h0,        3};
    tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h2, 32'h0,       0, 32'h0,        32'h0000ABCD, 1'b1, 4'h0, 32'h0,        32'h0,        1};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h2, 32'h0,       1, 32'h80017FFF, 32'hFFFF8001, 1'b0, 4'hC, 32'h0,        32'h0,        3};
    tbl[8]  = '{1'b1, 2'd0, 1'b0, 32'h1, 32'h00000055,0, 32'h0,        32'hFFFF8001, 1'b0, 4'h2, 32'h55555555, 32'h800155FF, 3};
    tbl[9]  = '{1'b0, 2'd3, 1'b0, 32'h0, 32'h0,       0, 32'h0,        32'hFFFF8001, 1'b1, 4'h0, 32'h0,        32'h0,        1};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h1, 32'hFFFF0000,0, 32'h0,        32'hFFFF8001, 1'b1, 4'h0, 32'h0,        32'h800155FF, 1};
    tbl[11] = '{1'b1, 2'd2, 1'b0, 32'hC, 32'hDEADBEEF,1, 32'h0,        32'hFFFF8001, 1'b0, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 3};

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].init) preload(int'(tbl[i].addr[5:2]), tbl[i].init_word);
      do_access(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, 0,
                g_rdata, g_err, g_sel, g_wbd, g_wba, g_we, g_busy, g_lat, g_cyc, g_stb, g_stable);
      check($sformatf("tbl%0d_latency", i), g_lat, tbl[i].exp_lat);
      check($sformatf("tbl%0d_err", i), {31'h0, g_err}, {31'h0, tbl[i].exp_err});
      check($sformatf("tbl%0d_rdata", i), g_rdata, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_busy_at_done", i), {31'h0, g_busy}, 32'd1);
      if (tbl[i].exp_err) begin
        check($sformatf("tbl%0d_no_cyc", i), g_cyc, 0);
      end else begin
        check($sformatf("tbl%0d_sel", i), {28'h0, g_sel}, {28'h0, tbl[i].exp_sel});
        check($sformatf("tbl%0d_wbdata", i), g_wbd, tbl[i].exp_wbd);
        check($sformatf("tbl%0d_wbaddr", i), g_wba, tbl[i].addr & 32'hFFFF_FFFC);
        check($sformatf("tbl%0d_wbwe", i), {31'h0, g_we}, {31'h0, tbl[i].we});
      end
      if (tbl[i].we)
        check($sformatf("tbl%0d_mem", i), mem[tbl[i].addr[5:2]], tbl[i].exp_mem);
    end
    last_rdata = 32'hFFFF8001;

    // Stall for 3 cycles: bus outputs stable, 3 extra cycles of latency.
    preload(2, 32'h13579BDF);
    do_access(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 3,
              g_rdata, g_err, g_sel, g_wbd, g_wba, g_we, g_busy, g_lat, g_cyc, g_stb, g_stable);
    check("stall_latency", g_lat, 6);
    check("stall_stb_cycles", g_stb, 4);
    check("stall_stable", {31'h0, g_stable}, 32'd1);
    check("stall_rdata", g_rdata, 32'h13579BDF);
    last_rdata = 32'h13579BDF;

    // Ack in the same cycle stb is accepted.
    comb_ack = 1'b1;
    preload(5, 32'h00C0FFEE);
    do_access(1'b0, 2'd0, 1'b1, 32'h15, 32'h0, 0,
              g_rdata, g_err, g_sel, g_wbd, g_wba, g_we, g_busy, g_lat, g_cyc, g_stb, g_stable);
    comb_ack = 1'b0;
    check("comb_ack_latency", g_lat, 2);
    check("comb_ack_rdata", g_rdata, 32'h000000FF);
    last_rdata = 32'h000000FF;

    // No ack at all: timeout after 16 cycles of cyc, rdata untouched.
    no_ack = 1'b1;
    do_access(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 0,
              g_rdata, g_err, g_sel, g_wbd, g_wba, g_we, g_busy, g_lat, g_cyc, g_stb, g_stable);
    no_ack = 1'b0;
    check("timeout_cyc_cycles", g_cyc, 16);
    check("timeout_latency", g_lat, 17);
    check("timeout_err", {31'h0, g_err}, 32'd1);
    check("timeout_rdata", g_rdata, last_rdata);

    // Ack arrives exactly in the last allowed cycle: it wins.
    preload(7, 32'hA5A5_5A5A);
    do_access(1'b0, 2'd2, 1'b0, 32'h1C, 32'h0, 14,
              g_rdata, g_err, g_sel, g_wbd, g_wba, g_we, g_busy, g_lat, g_cyc, g_stb, g_stable);
    check("limit_ack_err", {31'h0, g_err}, 32'd0);
    check("limit_ack_latency", g_lat, 17);
    check("limit_ack_rdata", g_rdata, 32'hA5A5_5A5A);
    last_rdata = 32'hA5A5_5A5A;

    // Stalled one cycle too long: times out in REQ.
    do_access(1'b0, 2'd2, 1'b0, 32'h1C, 32'h0, 15,
              g_rdata, g_err, g_sel, g_wbd, g_wba, g_we, g_busy, g_lat, g_cyc, g_stb, g_stable);
    check("limit_stall_err", {31'h0, g_err}, 32'd1);
    check("limit_stall_latency", g_lat, 17);
    repeat (2) @(negedge clk);

    // Reset while in WAIT: everything drops at once, no done afterwards.
    no_ack = 1'b1;
    @(negedge clk);
    we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h8; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_in_wait", {30'h0, wb_cyc, wb_stb}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_cycle", {busy, done, err, rdata, wb_cyc, wb_stb, wb_we, wb_addr,
                              wb_dout, wb_sel} == '0 ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    no_ack = 1'b0;
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check("no_done_after_reset", {31'h0, done_seen}, 32'd0);

    // New request after reset, with i_req pulses while busy ignored.
    preload(2, 32'h0BADF00D);
    acc0 = acc_cnt;
    @(negedge clk);
    we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h8; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    g_lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      req = (c <= 3);
      if (done && g_lat < 0) begin
        g_lat = c; g_rdata = rdata; g_err = err;
      end
    end
    req = 1'b0;
    check("post_reset_latency", g_lat, 3);
    check("post_reset_rdata", g_rdata, 32'h0BADF00D);
    check("post_reset_err", {31'h0, g_err}, 32'd0);
    check("busy_req_ignored", acc_cnt - acc0, 1);
    check("idle_after", {31'h0, busy}, 32'd0);
    last_rdata = 32'h0BADF00D;

    // Randomized accesses against the reference model.
    for (int t = 0; t < 60; t++) begin
      we = $urandom_range(0, 1);
      size = 2'($urandom_range(0, 3));
      uns = $urandom_range(0, 1);
      addr = $urandom_range(0, 63);
      wdata = $urandom;
      nst = $urandom_range(0, 2);
      idx = int'(addr[5:2]);
      old_word = $urandom;
      preload(idx, old_word);
      bad = m_bad(size, addr);
      do_access(we, size, uns, addr, wdata, nst,
                g_rdata, g_err, g_sel, g_wbd, g_wba, g_we, g_busy, g_lat, g_cyc, g_stb, g_stable);
      check($sformatf("rnd%0d_err", t), {31'h0, g_err}, {31'h0, bad});
      check($sformatf("rnd%0d_latency", t), g_lat, bad ? 1 : 3 + nst);
      if (bad) begin
        check($sformatf("rnd%0d_no_cyc", t), g_cyc, 0);
        check($sformatf("rnd%0d_rdata_kept", t), g_rdata, last_rdata);
      end else begin
        check($sformatf("rnd%0d_sel", t), {28'h0, g_sel}, {28'h0, m_sel(size, addr)});
        check($sformatf("rnd%0d_wbdata", t), g_wbd, m_wbd(we, size, wdata));
        check($sformatf("rnd%0d_wbaddr", t), g_wba, addr & 32'hFFFF_FFFC);
        check($sformatf("rnd%0d_stable", t), {31'h0, g_stable}, 32'd1);
        if (we) begin
          exp_word = m_store(old_word, m_sel(size, addr), m_wbd(we, size, wdata));
          check($sformatf("rnd%0d_mem", t), mem[idx], exp_word);
          check($sformatf("rnd%0d_rdata_kept", t), g_rdata, last_rdata);
        end else begin
          last_rdata = m_load(size, uns, addr, old_word);
          check($sformatf("rnd%0d_rdata", t), g_rdata, last_rdata);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
